// File: rtl/shift_reg_seq_if.sv
// Bus bundle for shift_reg_seq: control strobes, load data and status/data outputs.
// The parity signal exists only when SHIFT_REG_SEQ_PARITY_EN is defined.
interface shift_reg_seq_if #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
);
  logic             cl;
  logic             w;
  logic [WIDTH-1:0] din;
  logic [1:0]       mode;
  logic             dir;
  logic [STEP-1:0]  shift_in;
  logic             shift;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic [STEP-1:0]  shift_out;
`ifdef SHIFT_REG_SEQ_PARITY_EN
  logic             parity;

  modport master (
    output cl, w, din, mode, dir, shift_in, shift, start, count,
    input  busy, done, dout, shift_out, parity
  );
  modport slave (
    input  cl, w, din, mode, dir, shift_in, shift, start, count,
    output busy, done, dout, shift_out, parity
  );
`else
  modport master (
    output cl, w, din, mode, dir, shift_in, shift, start, count,
    input  busy, done, dout, shift_out
  );
  modport slave (
    input  cl, w, din, mode, dir, shift_in, shift, start, count,
    output busy, done, dout, shift_out
  );
`endif
endinterface

// File: rtl/shift_reg_seq.sv
// Multi-mode shift register (logical/rotate/arithmetic/fill) with an auto-sequenced
// N-step shift and busy/done handshake. Define SHIFT_REG_SEQ_PARITY_EN for a parity output.
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  shift_reg_seq_if.slave bus
);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [1:0]       MODE_ROT = 2'b01;
  localparam logic [1:0]       MODE_ARI = 2'b10;
  localparam logic [1:0]       MODE_FIL = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic [STEP-1:0]  r_sout, w_sout_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic             r_dir, w_dir_nxt;
  logic [1:0]       w_step_mode;
  logic             w_step_dir;

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] old, input logic [1:0] md,
                                               input logic dr, input logic [STEP-1:0] fill);
    logic [WIDTH-1:0] res;
    res = {WIDTH{1'b0}};
    if (dr) begin
      case (md)
        MODE_ROT: res = {old[WIDTH-1-STEP:0], old[WIDTH-1:WIDTH-STEP]};
        MODE_FIL: res = {old[WIDTH-1-STEP:0], fill};
        default:  res = {old[WIDTH-1-STEP:0], {STEP{1'b0}}};
      endcase
    end else begin
      case (md)
        MODE_ROT: res = {old[STEP-1:0], old[WIDTH-1:STEP]};
        MODE_ARI: res = {{STEP{old[WIDTH-1]}}, old[WIDTH-1:STEP]};
        MODE_FIL: res = {fill, old[WIDTH-1:STEP]};
        default:  res = {{STEP{1'b0}}, old[WIDTH-1:STEP]};
      endcase
    end
    return res;
  endfunction

  function automatic logic [STEP-1:0] f_expelled(input logic [WIDTH-1:0] old, input logic dr);
    return dr ? old[WIDTH-1:WIDTH-STEP] : old[STEP-1:0];
  endfunction

  // A running sequence uses the controls captured at start; single shifts use live ones.
  assign w_step_mode = (r_state == ST_RUN) ? r_mode : bus.mode;
  assign w_step_dir  = (r_state == ST_RUN) ? r_dir  : bus.dir;

  // Next-state and next-output logic; cl outranks everything, w/start/shift only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    w_sout_nxt  = r_sout;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_rem_nxt   = r_rem;
    w_mode_nxt  = r_mode;
    w_dir_nxt   = r_dir;
    if (bus.cl) begin
      w_state_nxt = ST_IDLE;
      w_dout_nxt  = {WIDTH{1'b0}};
      w_sout_nxt  = {STEP{1'b0}};
      w_busy_nxt  = 1'b0;
      w_rem_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.w) begin
            w_dout_nxt = bus.din;
          end else if (bus.start) begin
            if (bus.count == CNT_ZERO) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
              w_busy_nxt  = 1'b1;
              w_rem_nxt   = bus.count;
              w_mode_nxt  = bus.mode;
              w_dir_nxt   = bus.dir;
            end
          end else if (bus.shift) begin
            w_dout_nxt = f_step(r_dout, w_step_mode, w_step_dir, bus.shift_in);
            w_sout_nxt = f_expelled(r_dout, w_step_dir);
          end else begin
            w_dout_nxt = r_dout;
          end
        end
        ST_RUN: begin
          w_dout_nxt = f_step(r_dout, w_step_mode, w_step_dir, bus.shift_in);
          w_sout_nxt = f_expelled(r_dout, w_step_dir);
          // The last step lands here; the counter floors at zero.
          if (r_rem <= CNT_ONE) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_rem_nxt   = CNT_ZERO;
          end else begin
            w_rem_nxt = r_rem - CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_rem_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout <= {WIDTH{1'b0}};
      r_sout <= {STEP{1'b0}};
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_rem  <= CNT_ZERO;
      r_mode <= 2'b00;
      r_dir  <= 1'b0;
    end else begin
      r_dout <= w_dout_nxt;
      r_sout <= w_sout_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_rem  <= w_rem_nxt;
      r_mode <= w_mode_nxt;
      r_dir  <= w_dir_nxt;
    end
  end

  assign bus.dout      = r_dout;
  assign bus.shift_out = r_sout;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

`ifdef SHIFT_REG_SEQ_PARITY_EN
  logic r_parity;

  function automatic logic f_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Parity tracks the value dout takes on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= f_parity(w_dout_nxt);
    end
  end

  assign bus.parity = r_parity;
`endif
endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq: vector table, directed sequences and
// randomized traffic against a bit-level reference model.
module tb_shift_reg_seq;
  localparam int W  = 8;
  localparam int S  = 1;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shift_reg_seq_if #(.WIDTH(W), .STEP(1), .CNT_W(CW)) b1();
  shift_reg_seq_if #(.WIDTH(W), .STEP(4), .CNT_W(CW)) b4();

  shift_reg_seq #(.WIDTH(W), .STEP(1), .CNT_W(CW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  shift_reg_seq #(.WIDTH(W), .STEP(4), .CNT_W(CW)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  // reference model of dut1 (STEP = 1)
  logic [W-1:0] m_dout = '0;
  logic [S-1:0] m_sout = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_left = 0;
  logic [1:0]   m_mode = 2'b00;
  logic         m_dir  = 1'b0;

  typedef struct {
    logic       s4;
    logic [7:0] din;
    logic [1:0] md;
    logic       dr;
    logic [3:0] sin;
    logic [7:0] e_dout;
    logic [3:0] e_sout;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic [1:0] md, input logic dr);
    logic [W-1:0] o;
    logic [W-1:0] n;
    o = m_dout;
    n = '0;
    for (int i = 0; i < W; i++) begin
      if (!dr) begin
        if (i + S < W) n[i] = o[i+S];
        else if (md == 2'b01) n[i] = o[i+S-W];
        else if (md == 2'b10) n[i] = o[W-1];
        else if (md == 2'b11) n[i] = b1.shift_in[i+S-W];
        else n[i] = 1'b0;
      end else begin
        if (i >= S) n[i] = o[i-S];
        else if (md == 2'b01) n[i] = o[i+W-S];
        else if (md == 2'b11) n[i] = b1.shift_in[i];
        else n[i] = 1'b0;
      end
    end
    for (int j = 0; j < S; j++) m_sout[j] = dr ? o[W-S+j] : o[j];
    m_dout = n;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_dout = '0; m_sout = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (b1.cl) begin
      m_dout = '0; m_sout = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (b1.w) m_dout = b1.din;
      else if (b1.start) begin
        if (b1.count == 0) m_done = 1'b1;
        else begin
          m_left = int'(b1.count); m_mode = b1.mode; m_dir = b1.dir; m_busy = 1'b1;
        end
      end else if (b1.shift) model_step(b1.mode, b1.dir);
    end else begin
      model_step(m_mode, m_dir);
      m_left--;
      m_done = 1'b0;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    b1.cl = 1'b0; b1.w = 1'b0; b1.din = '0; b1.mode = 2'b00; b1.dir = 1'b0;
    b1.shift_in = '0; b1.shift = 1'b0; b1.start = 1'b0; b1.count = '0;
    b4.cl = 1'b0; b4.w = 1'b0; b4.din = '0; b4.mode = 2'b00; b4.dir = 1'b0;
    b4.shift_in = '0; b4.shift = 1'b0; b4.start = 1'b0; b4.count = '0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_dout"}, 32'(b1.dout), 32'(m_dout));
    chk({tag, "_sout"}, 32'(b1.shift_out), 32'(m_sout));
    chk({tag, "_busy"}, 32'(b1.busy), 32'(m_busy));
    chk({tag, "_done"}, 32'(b1.done), 32'(m_done));
`ifdef SHIFT_REG_SEQ_PARITY_EN
    chk({tag, "_parity"}, 32'(b1.parity), 32'(^m_dout));
`endif
  endtask

  initial begin
    logic [7:0] rot_exp[3];
    int nbusy, ndone, done_at;

    vt[0]  = '{1'b0, 8'hB4, 2'b00, 1'b0, 4'h0, 8'h5A, 4'h0};
    vt[1]  = '{1'b0, 8'hB4, 2'b00, 1'b1, 4'h0, 8'h68, 4'h1};
    vt[2]  = '{1'b0, 8'h81, 2'b01, 1'b0, 4'h0, 8'hC0, 4'h1};
    vt[3]  = '{1'b0, 8'h81, 2'b01, 1'b1, 4'h0, 8'h03, 4'h1};
    vt[4]  = '{1'b0, 8'h80, 2'b10, 1'b0, 4'h0, 8'hC0, 4'h0};
    vt[5]  = '{1'b0, 8'h41, 2'b10, 1'b1, 4'h0, 8'h82, 4'h0};
    vt[6]  = '{1'b0, 8'h41, 2'b11, 1'b0, 4'h1, 8'hA0, 4'h1};
    vt[7]  = '{1'b0, 8'h41, 2'b11, 1'b1, 4'h1, 8'h83, 4'h0};
    vt[8]  = '{1'b1, 8'h12, 2'b11, 1'b1, 4'hA, 8'h2A, 4'h1};
    vt[9]  = '{1'b1, 8'hC3, 2'b01, 1'b0, 4'h0, 8'h3C, 4'h3};
    vt[10] = '{1'b1, 8'h9F, 2'b10, 1'b0, 4'h0, 8'hF9, 4'hF};
    vt[11] = '{1'b1, 8'hB4, 2'b00, 1'b1, 4'h0, 8'h40, 4'hB};
    vt[12] = '{1'b1, 8'h5A, 2'b11, 1'b0, 4'h6, 8'h65, 4'hA};
    rot_exp = '{8'h5A, 8'h2D, 8'h96};

    // reset with a load request pending
    idle();
    rst_n = 1'b0; b1.w = 1'b1; b1.din = 8'hFF; b4.w = 1'b1; b4.din = 8'hFF;
    cycle();
    chk("rst_dout", 32'(b1.dout), 32'h0);
    chk("rst_sout", 32'(b1.shift_out), 32'h0);
    chk("rst_busy", 32'(b1.busy), 32'h0);
    chk("rst_done", 32'(b1.done), 32'h0);
    chk("rst_dout4", 32'(b4.dout), 32'h0);
    rst_n = 1'b1;
    idle();
    cycle();

    // single-step vector table
    for (int i = 0; i < 13; i++) begin
      idle();
      if (vt[i].s4) begin b4.w = 1'b1; b4.din = vt[i].din; end
      else begin b1.w = 1'b1; b1.din = vt[i].din; end
      cycle();
      idle();
      if (vt[i].s4) begin
        b4.shift = 1'b1; b4.mode = vt[i].md; b4.dir = vt[i].dr; b4.shift_in = vt[i].sin;
      end else begin
        b1.shift = 1'b1; b1.mode = vt[i].md; b1.dir = vt[i].dr; b1.shift_in = vt[i].sin[0:0];
      end
      cycle();
      if (vt[i].s4) begin
        chk($sformatf("vec%0d_dout", i), 32'(b4.dout), 32'(vt[i].e_dout));
        chk($sformatf("vec%0d_sout", i), 32'(b4.shift_out), 32'(vt[i].e_sout));
        chk($sformatf("vec%0d_busy", i), 32'(b4.busy), 32'h0);
      end else begin
        chk($sformatf("vec%0d_dout", i), 32'(b1.dout), 32'(vt[i].e_dout));
        chk($sformatf("vec%0d_sout", i), 32'(b1.shift_out), 32'(vt[i].e_sout));
      end
    end

    // auto rotate right x3, live mode/dir changed mid-run
    idle(); b1.w = 1'b1; b1.din = 8'hB4; cycle();
    idle(); b1.start = 1'b1; b1.mode = 2'b01; b1.dir = 1'b0; b1.count = 8'd3; cycle();
    chk("rot_k_busy", 32'(b1.busy), 32'h1);
    chk("rot_k_dout", 32'(b1.dout), 32'hB4);
    idle(); b1.mode = 2'b00; b1.dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("rot_step%0d_dout", i), 32'(b1.dout), 32'(rot_exp[i]));
      chk($sformatf("rot_step%0d_busy", i), 32'(b1.busy), (i == 2) ? 32'h0 : 32'h1);
      chk($sformatf("rot_step%0d_done", i), 32'(b1.done), (i == 2) ? 32'h1 : 32'h0);
    end
    chk("rot_sout", 32'(b1.shift_out), 32'h1);
    idle(); cycle();
    chk("rot_done_clr", 32'(b1.done), 32'h0);

    // arithmetic right x7 from 8'h80
    idle(); b1.w = 1'b1; b1.din = 8'h80; cycle();
    idle(); b1.start = 1'b1; b1.mode = 2'b10; b1.dir = 1'b0; b1.count = 8'd7; cycle();
    idle();
    nbusy = 0; ndone = 0; done_at = -1;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (b1.busy) nbusy++;
      if (b1.done) begin ndone++; done_at = c; end
      if (c == 7) begin
        chk("ari_dout", 32'(b1.dout), 32'hFF);
        chk("ari_sout", 32'(b1.shift_out), 32'h0);
      end
    end
    chk("ari_busy_cycles", 32'(nbusy), 32'd6);
    chk("ari_done_pulses", 32'(ndone), 32'd1);
    chk("ari_done_at", 32'(done_at), 32'd7);

    // zero count
    idle(); b1.start = 1'b1; b1.mode = 2'b01; b1.count = 8'd0; cycle();
    chk("zc_done", 32'(b1.done), 32'h1);
    chk("zc_busy", 32'(b1.busy), 32'h0);
    chk("zc_dout", 32'(b1.dout), 32'hFF);
    idle(); cycle();
    chk("zc_done_clr", 32'(b1.done), 32'h0);
    chk("zc_busy2", 32'(b1.busy), 32'h0);
    chk("zc_dout2", 32'(b1.dout), 32'hFF);

    // abort: load ignored during RUN, then cl
    idle(); b1.w = 1'b1; b1.din = 8'hFF; cycle();
    idle(); b1.start = 1'b1; b1.mode = 2'b00; b1.dir = 1'b0; b1.count = 8'd5; cycle();
    idle(); b1.w = 1'b1; b1.din = 8'h00; cycle();
    chk("ab_ignore_dout", 32'(b1.dout), 32'h7F);
    chk("ab_ignore_busy", 32'(b1.busy), 32'h1);
    idle(); b1.cl = 1'b1; cycle();
    chk("ab_cl_dout", 32'(b1.dout), 32'h0);
    chk("ab_cl_busy", 32'(b1.busy), 32'h0);
    chk("ab_cl_sout", 32'(b1.shift_out), 32'h0);
    idle();
    ndone = 0; nbusy = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (b1.done) ndone++;
      if (b1.busy) nbusy++;
    end
    chk("ab_no_done", 32'(ndone), 32'h0);
    chk("ab_no_busy", 32'(nbusy), 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      idle();
      rst_n       = ($urandom_range(0, 99) != 0);
      b1.cl       = ($urandom_range(0, 39) == 0);
      b1.w        = ($urandom_range(0, 7) == 0);
      b1.din      = 8'($urandom);
      b1.start    = ($urandom_range(0, 5) == 0);
      b1.count    = 8'($urandom_range(0, 6));
      b1.shift    = ($urandom_range(0, 1) == 1);
      b1.mode     = 2'($urandom_range(0, 3));
      b1.dir      = 1'($urandom_range(0, 1));
      b1.shift_in = 1'($urandom_range(0, 1));
      cycle();
      check_model("rnd");
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
